add_round_key_word: RTL and testbench
=====================================

Name: add_round_key_word

Overview:
- Performs the AES-128 AddRoundKey step on one 32-bit column word: result = mix-column word XOR round-key word.
- Sits after the MixColumns word stage and next to the key-expansion word source in the round datapath.
- The two operands may arrive in the same cycle or in different cycles. A one-entry hold per operand pairs them.
- The result is registered, with a one-cycle valid pulse.

Parameters:
- WORD_DATA_WIDTH, 32, width of the data word, key word and result (taken from the chip defines).

Ports:
- clock  input  1  system clock; all logic updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- word_in_comb_mix_column  input  WORD_DATA_WIDTH  data word from MixColumns.
- word_in_comb_mix_column_vld  input  1  data word valid; one word is accepted per cycle in which it is high.
- rnd_word_key_val  input  WORD_DATA_WIDTH  round-key word.
- rnd_word_key_val_vld  input  1  key word valid; one word is accepted per cycle in which it is high.
- word_out_comb  output  WORD_DATA_WIDTH  registered result, data XOR key.
- word_out_comb_vld  output  1  one-cycle pulse marking a new result.
- pair_overrun_err  output  1  sticky flag: a held operand was overwritten before it was paired.

Behaviour:
- Reset: one clock and one synchronous active-high reset.
  - On the reset edge: word_out_comb=0, word_out_comb_vld=0, pair_overrun_err=0, both holds emptied.
  - Inputs sampled while reset is high are ignored.
  - Reset asserted mid-operation discards any held operand; no result is produced for it.
- State per operand: hold register plus a full flag (data_hold/data_full, key_hold/key_full).
  - Both holds are never full at the end of a cycle.
- Effective operands each cycle:
  - data available = data_full OR data valid.
  - key available = key_full OR key valid.
  - Oldest first: a held operand takes priority over a newly arriving one of the same kind.
- Pairing: when data and key are both available, at the next edge:
  - word_out_comb = selected data XOR selected key (bitwise, full width, no carries).
  - word_out_comb_vld = 1.
  - The selected operands are consumed.
- Simultaneous events (all evaluated at the same edge):
  - Held data plus new data plus new key: held data pairs with the new key; the new data moves into data_hold and stays full.
  - Held key plus new key plus new data: mirror of the above.
  - New data and new key with both holds empty: they pair directly and both holds stay empty.
- Unpaired arrival: an operand with no partner available is written to its hold and its full flag is set.
- Overrun:
  - Condition: new data arrives while data_full=1 and no key is available (or the mirror for key).
  - The new word overwrites the hold (latest wins).
  - pair_overrun_err sets to 1 and stays set until reset.
- Latency: exactly 1 cycle from the edge where the second operand of a pair is sampled to word_out_comb_vld=1.
  - Throughput is one result per cycle when both valids are high every cycle.
- Output hold:
  - word_out_comb_vld is high only in the cycle after a pairing.
  - word_out_comb keeps the last result when no pairing occurs.
- Testbench timing: the bench drives inputs 1 time unit after the rising edge and samples outputs 1 time unit after it. All outputs are registered, so this timing is glitch-free.

Test Plan:
- Reset then simultaneous pair:
  - data=0x01234567 and key=0xFFFFFFFF, both valid in cycle N.
  - Required: vld=1 in N+1 with out=0xFEDCBA98; vld=0 in N+2 and out still 0xFEDCBA98.
- Key first:
  - Cycle N: key=0xA5A5A5A5 valid alone; required vld=0 in N+1.
  - Cycle N+3: data=0x5A5A5A5A valid.
  - Required: vld=1 in N+4 with out=0xFFFFFFFF.
- Streaming:
  - Both valids high for 4 cycles; data = 0x00000000, 0x11111111, 0x22222222, 0x33333333; key constant 0x0F0F0F0F.
  - Required: 4 consecutive vld pulses with out = 0x0F0F0F0F, 0x1E1E1E1E, 0x2D2D2D2D, 0x3C3C3C3C.
- Held data plus new data plus new key:
  - Cycle N: data D1=0x11111111 alone.
  - Cycle N+1: D2=0x22222222 and key K1=0x000000FF together.
  - Required in N+2: out=0x111111EE; D2 stays held.
  - Then K2=0x22222222 valid in N+3; required in N+4: out=0x00000000.
- Overrun:
  - Data 0xDEADBEEF, then data 0xCAFEBABE, with no key in between.
  - Required: pair_overrun_err=1 from the next edge.
  - Then key 0x00000000; required: out=0xCAFEBABE.
- Reset mid-operation:
  - Hold data 0x12345678, pulse reset for 1 cycle, then send key 0x87654321 alone.
  - Required: no vld pulse, out=0, err=0.

Source files
------------

// File: rtl/add_round_key_word.sv
// AES-128 AddRoundKey on one 32-bit column word.
// The data and key operands may arrive in different cycles, so each has a
// one-entry hold. The result (data XOR key) is registered with a one-cycle
// valid pulse. A sticky flag records any held operand that was overwritten
// before it could be paired.
module add_round_key_word #(
  parameter int unsigned WORD_DATA_WIDTH = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [WORD_DATA_WIDTH-1:0] word_in_comb_mix_column,
  input  logic                       word_in_comb_mix_column_vld,
  input  logic [WORD_DATA_WIDTH-1:0] rnd_word_key_val,
  input  logic                       rnd_word_key_val_vld,
  output logic [WORD_DATA_WIDTH-1:0] word_out_comb,
  output logic                       word_out_comb_vld,
  output logic                       pair_overrun_err
);

  logic [WORD_DATA_WIDTH-1:0] data_hold;
  logic [WORD_DATA_WIDTH-1:0] key_hold;
  logic                       data_full;
  logic                       key_full;

  logic                       data_avail;
  logic                       key_avail;
  logic                       pair;
  logic [WORD_DATA_WIDTH-1:0] sel_data;
  logic [WORD_DATA_WIDTH-1:0] sel_key;
  logic                       data_overrun;
  logic                       key_overrun;

  // Operand selection: a held operand is older, so it is used ahead of a new one.
  always_comb begin
    data_avail   = data_full | word_in_comb_mix_column_vld;
    key_avail    = key_full  | rnd_word_key_val_vld;
    pair         = data_avail & key_avail;
    sel_data     = data_full ? data_hold : word_in_comb_mix_column;
    sel_key      = key_full  ? key_hold  : rnd_word_key_val;
    data_overrun = word_in_comb_mix_column_vld & data_full & ~key_avail;
    key_overrun  = rnd_word_key_val_vld & key_full & ~data_avail;
  end

  // Result register, valid pulse and sticky overrun flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      word_out_comb     <= '0;
      word_out_comb_vld <= 1'b0;
      pair_overrun_err  <= 1'b0;
    end else begin
      word_out_comb_vld <= pair;
      if (pair) begin
        word_out_comb <= sel_data ^ sel_key;
      end
      if (data_overrun || key_overrun) begin
        pair_overrun_err <= 1'b1;
      end
    end
  end

  // Data hold: a new word is parked unless it pairs directly; a held word
  // consumed by a pairing is replaced by any new word arriving in that cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      data_hold <= '0;
      data_full <= 1'b0;
    end else if (word_in_comb_mix_column_vld) begin
      data_hold <= word_in_comb_mix_column;
      data_full <= data_full | ~pair;
    end else if (pair) begin
      data_full <= 1'b0;
    end
  end

  // Key hold: mirror of the data hold.
  always_ff @(posedge clock) begin
    if (reset) begin
      key_hold <= '0;
      key_full <= 1'b0;
    end else if (rnd_word_key_val_vld) begin
      key_hold <= rnd_word_key_val;
      key_full <= key_full | ~pair;
    end else if (pair) begin
      key_full <= 1'b0;
    end
  end

endmodule

// File: tb/tb_add_round_key_word.sv
// Directed, table-driven bench for add_round_key_word.
module tb_add_round_key_word;

  localparam int unsigned W = 32;

  logic         clock;
  logic         reset;
  logic [W-1:0] data;
  logic         data_vld;
  logic [W-1:0] key;
  logic         key_vld;
  logic [W-1:0] out;
  logic         out_vld;
  logic         err;

  int tests;
  int fails;

  add_round_key_word #(.WORD_DATA_WIDTH(W)) dut (
    .clock                       (clock),
    .reset                       (reset),
    .word_in_comb_mix_column     (data),
    .word_in_comb_mix_column_vld (data_vld),
    .rnd_word_key_val            (key),
    .rnd_word_key_val_vld        (key_vld),
    .word_out_comb               (out),
    .word_out_comb_vld           (out_vld),
    .pair_overrun_err            (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic         rst;
    logic         dv;
    logic [W-1:0] d;
    logic         kv;
    logic [W-1:0] k;
    logic         e_vld;
    logic [W-1:0] e_out;
    logic         e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic dv, logic [W-1:0] d, logic kv, logic [W-1:0] k,
                              logic e_vld, logic [W-1:0] e_out, logic e_err);
    vec_t v;
    v.rst = rst; v.dv = dv; v.d = d; v.kv = kv; v.k = k;
    v.e_vld = e_vld; v.e_out = e_out; v.e_err = e_err;
    return v;
  endfunction

  task automatic check(string name, logic e_vld, logic [W-1:0] e_out, logic e_err);
    tests++;
    if (out_vld !== e_vld || out !== e_out || err !== e_err) begin
      fails++;
      $display("FAIL %s: got vld=%b out=%h err=%b, expected vld=%b out=%h err=%b",
               name, out_vld, out, err, e_vld, e_out, e_err);
    end
  endtask

  initial begin
    int lat;
    tests = 0;
    fails = 0;
    reset = 1'b1; data = '0; data_vld = 1'b0; key = '0; key_vld = 1'b0;

    // rst dv  data          kv  key           e_vld e_out         e_err
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h0,        0, 32'h00000000, 0)); // reset state
    vecs.push_back(mk(0, 1, 32'h01234567, 1, 32'hFFFFFFFF, 1, 32'hFEDCBA98, 0)); // simultaneous pair
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 32'hFEDCBA98, 0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'hA5A5A5A5, 0, 32'hFEDCBA98, 0)); // key first
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 32'hFEDCBA98, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 32'hFEDCBA98, 0));
    vecs.push_back(mk(0, 1, 32'h5A5A5A5A, 0, 32'h0,        1, 32'hFFFFFFFF, 0));
    vecs.push_back(mk(0, 1, 32'h00000000, 1, 32'h0F0F0F0F, 1, 32'h0F0F0F0F, 0)); // streaming
    vecs.push_back(mk(0, 1, 32'h11111111, 1, 32'h0F0F0F0F, 1, 32'h1E1E1E1E, 0));
    vecs.push_back(mk(0, 1, 32'h22222222, 1, 32'h0F0F0F0F, 1, 32'h2D2D2D2D, 0));
    vecs.push_back(mk(0, 1, 32'h33333333, 1, 32'h0F0F0F0F, 1, 32'h3C3C3C3C, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h3C3C3C3C, 0));
    vecs.push_back(mk(0, 1, 32'h11111111, 0, 32'h0,        0, 32'h3C3C3C3C, 0)); // held+new data+new key
    vecs.push_back(mk(0, 1, 32'h22222222, 1, 32'h000000FF, 1, 32'h111111EE, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h111111EE, 0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h22222222, 1, 32'h00000000, 0));
    vecs.push_back(mk(0, 1, 32'hDEADBEEF, 0, 32'h0,        0, 32'h00000000, 0)); // data overrun
    vecs.push_back(mk(0, 1, 32'hCAFEBABE, 0, 32'h0,        0, 32'h00000000, 1));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h00000000, 1, 32'hCAFEBABE, 1));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 32'hCAFEBABE, 1));
    vecs.push_back(mk(0, 1, 32'h12345678, 0, 32'h0,        0, 32'hCAFEBABE, 1)); // reset mid-op
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h0,        0, 32'h00000000, 0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h87654321, 0, 32'h00000000, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h00000000, 0));
    vecs.push_back(mk(0, 1, 32'hAAAAAAAA, 0, 32'h0,        1, 32'h2DCFE98B, 0)); // data meets held key
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h0000FFFF, 0, 32'h2DCFE98B, 0)); // held+new key+new data
    vecs.push_back(mk(0, 1, 32'h12345678, 1, 32'hFFFF0000, 1, 32'h1234A987, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h1234A987, 0));
    vecs.push_back(mk(0, 1, 32'hFFFFFFFF, 0, 32'h0,        1, 32'h0000FFFF, 0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h11111111, 0, 32'h0000FFFF, 0)); // key overrun
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h22222222, 0, 32'h0000FFFF, 1));
    vecs.push_back(mk(0, 1, 32'h33333333, 0, 32'h0,        1, 32'h11111111, 1));
    vecs.push_back(mk(1, 1, 32'h55555555, 1, 32'h0,        0, 32'h00000000, 0)); // inputs ignored in reset
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h12121212, 0, 32'h00000000, 0));
    vecs.push_back(mk(0, 1, 32'h03030303, 0, 32'h0,        1, 32'h11111111, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h11111111, 0));

    @(posedge clock);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst; data_vld = vecs[i].dv; data = vecs[i].d;
      key_vld = vecs[i].kv; key = vecs[i].k;
      @(posedge clock);
      #1;
      check($sformatf("vec%0d", i), vecs[i].e_vld, vecs[i].e_out, vecs[i].e_err);
    end

    // Latency check with a bounded wait: pair must appear exactly one edge later.
    reset = 1'b0; data_vld = 1'b1; data = 32'hF0F0F0F0; key_vld = 1'b1; key = 32'h0FF00FF0;
    @(posedge clock);
    #1;
    data_vld = 1'b0; key_vld = 1'b0;
    lat = 1;
    while (!out_vld && lat < 8) begin
      @(posedge clock);
      #1;
      lat++;
    end
    tests++;
    if (lat != 1) begin
      fails++;
      $display("FAIL latency: got %0d cycles, expected 1", lat);
    end
    check("latency_out", 1'b1, 32'hFF00FF00, 1'b0);
    @(posedge clock);
    #1;
    check("pulse_drop", 1'b0, 32'hFF00FF00, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
